pkt_hdr_ins: RTL and testbench
==============================

Name: pkt_hdr_ins

Overview:
- Sits directly downstream of the packet segmenter.
- Consumes its 8-bit sop/eop/vld byte stream of 46..1500-byte packets.
- Buffers each packet store-and-forward, then re-emits it with a 4-byte header prepended, under a valid/ready output handshake.
- Drops packets it cannot buffer, or that are malformed, and counts the drops.

Parameters:
- MAX_LEN, 1500: longest legal payload in bytes; longer packets are dropped.
- MIN_LEN, 46: shortest legal payload in bytes; shorter packets are dropped.
- DFIFO_AW, 12: data buffer address width; depth is 2^DFIFO_AW bytes (4096).
- MFIFO_AW, 4: length FIFO address width; depth is 16 entries.
- SYNC_BYTE, 8'h55: first header byte.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- din  in  8  input byte
- din_vld  in  1  input byte valid; no backpressure toward upstream
- din_sop  in  1  first byte of packet, qualified by din_vld
- din_eop  in  1  last byte of packet, qualified by din_vld
- dout  out  8  output byte
- dout_vld  out  1  output byte valid
- dout_sop  out  1  first header byte
- dout_eop  out  1  last payload byte
- dout_rdy  in  1  downstream accepts the byte when dout_vld && dout_rdy
- drop_cnt  out  16  dropped-packet count, saturates at 16'hFFFF

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: dout=0, dout_vld=0, dout_sop=0, dout_eop=0, drop_cnt=0. Buffers empty, seq=0, read FSM in IDLE.
- Buffers: data RAM and length FIFO are built in RTL, with no vendor IP. The data buffer has a committed write pointer wp_c and a speculative pointer wp_s.
- Write side, states WIDLE / WACC / WDROP:
  - WIDLE, din_vld&&din_sop:
    - If free space (measured from wp_c) >= MAX_LEN and the length FIFO is not full: write the byte at wp_s, set len=1, go to WACC.
    - Otherwise go to WDROP.
    - A single-byte packet (sop&&eop) is too short, is counted as a drop, and the FSM stays in WIDLE.
  - WIDLE, din_vld without sop: the byte is ignored and is not counted.
  - WACC, din_vld: write the byte and increment len.
    - On eop with MIN_LEN <= len+1 <= MAX_LEN: set wp_c=wp_s+1, push len+1 (16 bits) to the length FIFO, go to WIDLE.
    - On eop with len+1 out of range: roll wp_s back to wp_c, increment drop_cnt, go to WIDLE.
    - len reaching MAX_LEN without eop: roll back, increment drop_cnt, go to WDROP.
    - din_sop inside WACC: abort the current packet (roll back, increment drop_cnt), then evaluate this byte as a new sop exactly as in WIDLE.
  - WDROP: discard bytes until din_vld&&din_eop, then go to WIDLE. drop_cnt increments once per dropped packet, on entry to WDROP.
  - A sop byte that arrives in WDROP starts a new evaluation, as in WIDLE.
- Read side, states IDLE / HDR / DATA. The output register advances only when !dout_vld || dout_rdy ("adv"). Outputs hold stable while dout_vld && !dout_rdy.
  - IDLE: when the length FIFO is non-empty and adv, pop the length L, present SYNC_BYTE with dout_sop=1, go to HDR.
  - HDR: on each adv, present seq, then L[15:8], then L[7:0]. After the 4th header byte is accepted, go to DATA.
  - DATA: on each adv, present the next payload byte. dout_eop=1 on byte L.
    - When byte L is accepted, seq increments (8-bit wrap), and the FSM goes to IDLE, or directly to the next header if a length is pending. There are no idle cycles between packets when dout_rdy stays 1.
- RAM read: the RAM read has 1-cycle latency. Prefetch so that continuous dout_rdy=1 yields one byte per cycle.
- Latency: with dout_rdy=1, header byte 0 is valid 2 cycles after the input eop cycle.
- Simultaneous read/write on the same cycle is legal. Free space is computed from wp_c and the read pointer.
- Reset mid-packet: all state is cleared and partial packets are lost. drop_cnt does not count them.

Test Plan:
- Single 46-byte packet 0x00..0x2D, dout_rdy=1 -> 50 bytes out: 55,00,00,2E, then 00..2D. sop on byte 0, eop on byte 49, first output 2 cycles after din eop.
- Three back-to-back 1500-byte packets, dout_rdy=1 -> headers 55,00,05,DC / 55,01,05,DC / 55,02,05,DC. No drops. Payload is byte-exact.
- dout_rdy toggling randomly at 50% during a 100-byte packet -> dout/sop/eop stable while stalled. 104 accepted bytes, correct order.
- dout_rdy=0 held while four 1500-byte packets arrive -> the first two are buffered (3000 bytes; the third fails the free-space check), the third and fourth are dropped, drop_cnt=2. Release dout_rdy -> two packets emitted, seq 0 and 1.
- 1501-byte packet, then a 20-byte packet, then a 46-byte packet -> drop_cnt=2. Only the 46-byte packet is output, with header 55,00,00,2E.
- sop at byte 10 of a packet, then a valid 60-byte packet -> first packet aborted (drop_cnt=1), 60-byte packet output. Assert rst_n low mid-output -> all outputs 0 next cycle, drop_cnt=0.

Source files
------------

// File: rtl/pkt_hdr_ins.sv
// Store-and-forward header inserter.
// Buffers each sop/eop byte packet, drops malformed or unbufferable ones,
// and re-emits accepted packets with a 4-byte header
// (SYNC_BYTE, seq, len[15:8], len[7:0]) under a valid/ready handshake.
module pkt_hdr_ins #(
  parameter int         MAX_LEN   = 1500,
  parameter int         MIN_LEN   = 46,
  parameter int         DFIFO_AW  = 12,
  parameter int         MFIFO_AW  = 4,
  parameter logic [7:0] SYNC_BYTE = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  input  logic        dout_rdy,
  output logic [15:0] drop_cnt
);

  localparam int PW     = DFIFO_AW + 1;
  localparam int MPW    = MFIFO_AW + 1;
  localparam int DEPTH  = 1 << DFIFO_AW;
  localparam int MDEPTH = 1 << MFIFO_AW;

  typedef enum logic [1:0] {WIDLE, WACC, WDROP} wstate_t;
  typedef enum logic [1:0] {IDLE, HDR, DATA} rstate_t;

  // Saturating increment of the drop counter (up to two drops per cycle
  // when an abort and a rejected restart coincide).
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Data buffer and length FIFO storage
  logic [7:0]          mem [0:DEPTH-1];
  logic [7:0]          rdata_p1;
  logic [15:0]         mf_mem [0:MDEPTH-1];

  // Write side
  wstate_t             wstate, wstate_n;
  logic [PW-1:0]       wp_c, wp_s, wp_c_n, wp_s_n;
  logic [15:0]         len, len_n, len_p1;
  logic                len_ok;
  logic                we, push, start, space_ok;
  logic [DFIFO_AW-1:0] waddr;
  logic [1:0]          drop_inc;
  logic [PW-1:0]       used, free;

  // Length FIFO pointers
  logic [MPW-1:0]      mf_wp, mf_rp;
  logic                mf_full, mf_empty, pop;
  logic [15:0]         mf_head;

  // Read side
  rstate_t             rstate, rstate_n;
  logic [1:0]          hcnt, hcnt_n;
  logic [15:0]         rlen, rlen_n, bcnt, bcnt_n;
  logic [7:0]          seq, seq_n;
  logic [PW-1:0]       rp, rp_n;
  logic [DFIFO_AW-1:0] raddr;
  logic                adv, consume;
  logic [7:0]          dout_n;
  logic                vld_n, sop_n, eop_n;

  assign used     = wp_c - rp;
  assign free     = PW'(DEPTH) - used;
  assign mf_empty = (mf_wp == mf_rp);
  assign mf_full  = (mf_wp[MFIFO_AW] != mf_rp[MFIFO_AW]) &&
                    (mf_wp[MFIFO_AW-1:0] == mf_rp[MFIFO_AW-1:0]);
  assign space_ok = (free >= PW'(MAX_LEN)) && !mf_full;
  assign mf_head  = mf_mem[mf_rp[MFIFO_AW-1:0]];
  assign len_p1   = len + 16'd1;
  assign len_ok   = (len_p1 >= 16'(MIN_LEN)) && (len_p1 <= 16'(MAX_LEN));

  // Write FSM: accumulate at wp_s, commit to wp_c on a legal eop, roll back otherwise
  always_comb begin
    wstate_n = wstate;
    wp_s_n   = wp_s;
    wp_c_n   = wp_c;
    len_n    = len;
    we       = 1'b0;
    waddr    = wp_s[DFIFO_AW-1:0];
    drop_inc = 2'd0;
    push     = 1'b0;
    start    = 1'b0;
    if (din_vld) begin
      case (wstate)
        WIDLE: start = din_sop;
        WACC: begin
          if (din_sop) begin
            // A new sop aborts the packet in flight, then is evaluated afresh
            drop_inc = 2'd1;
            wp_s_n   = wp_c;
            wstate_n = WIDLE;
            start    = 1'b1;
          end else begin
            we     = 1'b1;
            wp_s_n = wp_s + PW'(1);
            len_n  = len_p1;
            if (din_eop) begin
              wstate_n = WIDLE;
              if (len_ok) begin
                wp_c_n = wp_s + PW'(1);
                push   = 1'b1;
              end else begin
                wp_s_n   = wp_c;
                drop_inc = 2'd1;
              end
            end else if (len_p1 == 16'(MAX_LEN)) begin
              wp_s_n   = wp_c;
              drop_inc = 2'd1;
              wstate_n = WDROP;
            end
          end
        end
        WDROP: begin
          if (din_sop)      start    = 1'b1;
          else if (din_eop) wstate_n = WIDLE;
        end
        default: wstate_n = WIDLE;
      endcase
      if (start) begin
        if (din_eop) begin
          // Single-byte packet is always too short
          drop_inc = drop_inc + 2'd1;
          wstate_n = WIDLE;
        end else if (space_ok) begin
          // Outside WACC the speculative pointer always equals wp_c
          we       = 1'b1;
          waddr    = wp_c[DFIFO_AW-1:0];
          wp_s_n   = wp_c + PW'(1);
          len_n    = 16'd1;
          wstate_n = WACC;
        end else begin
          drop_inc = drop_inc + 2'd1;
          wstate_n = WDROP;
        end
      end
    end
  end

  // Write-side state, pointers and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate   <= WIDLE;
      wp_c     <= '0;
      wp_s     <= '0;
      len      <= '0;
      drop_cnt <= '0;
      mf_wp    <= '0;
    end else begin
      wstate   <= wstate_n;
      wp_c     <= wp_c_n;
      wp_s     <= wp_s_n;
      len      <= len_n;
      drop_cnt <= sat_add(drop_cnt, drop_inc);
      if (push) mf_wp <= mf_wp + MPW'(1);
    end
  end

  // Read FSM: header bytes, then payload from the prefetched RAM word
  always_comb begin
    adv      = !dout_vld || dout_rdy;
    rstate_n = rstate;
    hcnt_n   = hcnt;
    rlen_n   = rlen;
    bcnt_n   = bcnt;
    seq_n    = seq;
    dout_n   = dout;
    vld_n    = dout_vld;
    sop_n    = dout_sop;
    eop_n    = dout_eop;
    pop      = 1'b0;
    consume  = 1'b0;
    if (adv) begin
      vld_n = 1'b0;
      sop_n = 1'b0;
      eop_n = 1'b0;
      case (rstate)
        IDLE: begin
          if (!mf_empty) begin
            pop      = 1'b1;
            rlen_n   = mf_head;
            dout_n   = SYNC_BYTE;
            vld_n    = 1'b1;
            sop_n    = 1'b1;
            hcnt_n   = 2'd1;
            rstate_n = HDR;
          end
        end
        HDR: begin
          vld_n = 1'b1;
          case (hcnt)
            2'd1:    dout_n = seq;
            2'd2:    dout_n = rlen[15:8];
            default: dout_n = rlen[7:0];
          endcase
          hcnt_n = hcnt + 2'd1;
          if (hcnt == 2'd3) begin
            bcnt_n   = 16'd0;
            rstate_n = DATA;
          end
        end
        DATA: begin
          vld_n   = 1'b1;
          dout_n  = rdata_p1;
          consume = 1'b1;
          bcnt_n  = bcnt + 16'd1;
          if (bcnt + 16'd1 == rlen) begin
            // IDLE pops the next length on the very next adv, so no gap
            eop_n    = 1'b1;
            seq_n    = seq + 8'd1;
            rstate_n = IDLE;
          end
        end
        default: rstate_n = IDLE;
      endcase
    end
    rp_n  = consume ? rp + PW'(1) : rp;
    raddr = rp_n[DFIFO_AW-1:0];
  end

  // Read-side state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate   <= IDLE;
      hcnt     <= '0;
      rlen     <= '0;
      bcnt     <= '0;
      seq      <= '0;
      rp       <= '0;
      mf_rp    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      rstate   <= rstate_n;
      hcnt     <= hcnt_n;
      rlen     <= rlen_n;
      bcnt     <= bcnt_n;
      seq      <= seq_n;
      rp       <= rp_n;
      if (pop) mf_rp <= mf_rp + MPW'(1);
      dout     <= dout_n;
      dout_vld <= vld_n;
      dout_sop <= sop_n;
      dout_eop <= eop_n;
    end
  end

  // Data RAM: rdata_p1 always holds the byte at the read pointer
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    rdata_p1 <= mem[raddr];
  end

  // Length FIFO storage
  always_ff @(posedge clk) begin
    if (push) mf_mem[mf_wp[MFIFO_AW-1:0]] <= len_p1;
  end

endmodule

// File: tb/tb_pkt_hdr_ins.sv
// Scoreboard bench for pkt_hdr_ins: packet-level reference model feeds an
// expected-byte queue; an independent monitor checks every accepted byte.
module tb_pkt_hdr_ins;

  localparam int MAXL  = 1500;
  localparam int MINL  = 46;
  localparam int DEPTH = 4096;
  localparam int MFD   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic        dout_rdy = 1'b0;
  logic [7:0]  dout;
  logic        dout_vld, dout_sop, dout_eop;
  logic [15:0] drop_cnt;

  pkt_hdr_ins dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_sop(din_sop), .din_eop(din_eop), .dout(dout), .dout_vld(dout_vld),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_rdy(dout_rdy),
    .drop_cnt(drop_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       hdr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_committed = 0, m_pushed = 0, m_drops = 0, m_seq = 0;
  int   m_consumed = 0, m_hdrs = 0;
  int   n_acc = 0;
  int   rdy_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Downstream ready: 0 = held low, 1 = held high, 2 = 50 %, 3 = 75 %
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       dout_rdy = 1'b0;
      1:       dout_rdy = 1'b1;
      2:       dout_rdy = 1'($urandom_range(0, 1));
      default: dout_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops an expectation for every accepted byte, checks stall stability
  initial begin
    logic       stall;
    logic [7:0] p_d;
    logic       p_s, p_e;
    exp_t       e;
    stall = 1'b0; p_d = 8'h00; p_s = 1'b0; p_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_consumed = 0;
        m_hdrs = 0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_vld", 32'(dout_vld), 32'd1);
          check("stall_hold", {21'd0, dout, dout_sop, dout_eop, 1'b0}, {21'd0, p_d, p_s, p_e, 1'b0});
        end
        if (dout_vld && dout_rdy) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(dout), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("dout", 32'(dout), 32'(e.d));
            check("dout_sop", 32'(dout_sop), 32'(e.sop));
            check("dout_eop", 32'(dout_eop), 32'(e.eop));
            if (!e.hdr) m_consumed++;
            else if (e.sop) m_hdrs++;
          end
        end
        stall = dout_vld && !dout_rdy;
        p_d = dout; p_s = dout_sop; p_e = dout_eop;
      end
    end
  end

  function automatic bit model_space_ok();
    return ((DEPTH - (m_committed - m_consumed)) >= MAXL) && ((m_pushed - m_hdrs) < MFD);
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic s, input logic e, input logic h);
    exp_t x;
    x.d = d; x.sop = s; x.eop = e; x.hdr = h;
    exp_q.push_back(x);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic s, input logic e);
    din = b; din_vld = 1'b1; din_sop = s; din_eop = e;
    @(posedge clk);
    #1;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one packet of n bytes (eop on the last byte only if term).
  // Accepted exactly when complete, of legal length and buffer space exists at sop.
  task automatic send_pkt(input int n, input bit term, input bit incr);
    logic [7:0] pl[$];
    logic [7:0] b;
    bit ok;
    ok = term && (n >= MINL) && (n <= MAXL) && model_space_ok();
    for (int i = 0; i < n; i++) begin
      b = incr ? 8'(i) : 8'($urandom);
      pl.push_back(b);
      drive_byte(b, i == 0, term && (i == n - 1));
    end
    if (ok) begin
      m_committed += n;
      m_pushed++;
      push_exp(8'h55, 1'b1, 1'b0, 1'b1);
      push_exp(8'(m_seq), 1'b0, 1'b0, 1'b1);
      push_exp(8'(n >> 8), 1'b0, 1'b0, 1'b1);
      push_exp(8'(n), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) push_exp(pl[i], 1'b0, i == n - 1, 1'b0);
      m_seq = (m_seq + 1) % 256;
    end else begin
      m_drops++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_vld", 32'(dout_vld), 32'd0);
    check("rst_sop_eop", {30'd0, dout_sop, dout_eop}, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_committed = 0; m_pushed = 0; m_drops = 0; m_seq = 0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 32'd0);
    idle(4);
    check({name, "_idle_vld"}, 32'(dout_vld), 32'd0);
    check({name, "_drop_cnt"}, 32'(drop_cnt), m_drops);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k, kind, n;
    bit force_good;
    #1;
    do_reset();
    idle(2);

    // T1: 46-byte incrementing packet, latency of first header byte
    rdy_mode = 1;
    idle(2);
    send_pkt(46, 1'b1, 1'b1);
    @(negedge clk);
    check("lat_not_early", 32'(dout_vld), 32'd0);
    @(negedge clk);
    check("lat_hdr0", {29'd0, dout_vld, dout_sop, dout_eop}, {29'd0, 3'b110});
    check("lat_sync", 32'(dout), 32'h55);
    @(posedge clk);
    #1;
    drain("t1");

    // T2: three back-to-back maximum-length packets
    do_reset();
    for (int i = 0; i < 3; i++) send_pkt(1500, 1'b1, 1'b0);
    drain("t2");
    check("t2_no_drops", 32'(drop_cnt), 32'd0);

    // T3: 100-byte packet under random backpressure
    do_reset();
    rdy_mode = 2;
    n0 = n_acc;
    send_pkt(100, 1'b1, 1'b0);
    drain("t3");
    check("t3_accepted", n_acc - n0, 32'd104);
    rdy_mode = 1;

    // T4: output stalled while four max packets arrive; two fit
    do_reset();
    rdy_mode = 0;
    idle(2);
    for (int i = 0; i < 4; i++) send_pkt(1500, 1'b1, 1'b0);
    idle(5);
    check("t4_drops_stalled", 32'(drop_cnt), 32'd2);
    check("t4_hdr_held", {23'd0, dout_vld, dout}, {23'd0, 1'b1, 8'h55});
    rdy_mode = 1;
    drain("t4");

    // T5: too long, too short, then minimum length
    do_reset();
    send_pkt(1501, 1'b1, 1'b0);
    send_pkt(20, 1'b1, 1'b0);
    send_pkt(46, 1'b1, 1'b1);
    drain("t5");
    check("t5_drops", 32'(drop_cnt), 32'd2);

    // T6: sop inside a packet aborts it; reset during output
    do_reset();
    send_pkt(10, 1'b0, 1'b0);
    send_pkt(60, 1'b1, 1'b0);
    k = 0;
    while (!dout_vld && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("t6_out_started", 32'(dout_vld), 32'd1);
    idle(10);
    check("t6_drop_abort", 32'(drop_cnt), 32'd1);
    check("t6_mid_output", 32'(dout_vld), 32'd1);
    do_reset();
    idle(3);
    check("t6_quiet_after_rst", 32'(dout_vld), 32'd0);

    // T7: randomized mix of good, short, long, aborted, single-byte packets and stray bytes
    do_reset();
    rdy_mode = 3;
    force_good = 1'b0;
    for (int it = 0; it < 30; it++) begin
      kind = force_good ? 0 : int'($urandom_range(0, 9));
      force_good = 1'b0;
      case (kind)
        5:       begin n = int'($urandom_range(2, 45));     send_pkt(n, 1'b1, 1'b0); end
        6:       begin n = int'($urandom_range(1, 60));     send_pkt(n, 1'b0, 1'b0); force_good = 1'b1; end
        7:       begin n = 1;                                send_pkt(n, 1'b1, 1'b0); end
        8:       begin n = int'($urandom_range(1501, 1505)); send_pkt(n, 1'b1, 1'b0); end
        9:       begin n = int'($urandom_range(45, 47));     send_pkt(n, 1'b1, 1'b0); end
        default: begin n = int'($urandom_range(46, 200));    send_pkt(n, 1'b1, 1'b0); end
      endcase
      if (!force_good) begin
        if ($urandom_range(0, 3) == 0) drive_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        idle(n + int'($urandom_range(0, 5)));
      end
    end
    drain("t7");
    rdy_mode = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
